alu_exec_unit: RTL
==================

# alu_exec_unit

- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, together with the operands and shift amount.
- Returns a registered result with zero, overflow and illegal-code flags.
- Sits between the ID/EX pipeline register and EX/MEM, using valid/ready handshakes on both sides.
- Logic and arithmetic operations complete in one cycle; sll/srl use a serial one-bit-per-cycle shifter that back-pressures the upstream stage.

## Interface
- `WIDTH`, 32: datapath width; shift amount is fixed at 5 bits.
- `TAGW`, 5: width of the destination-register tag carried alongside each operation.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of the in-flight and buffered operation.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit can accept an operation this cycle.
- `alu_ctrl`  in  4  operation code: 0000 add, 0001 sub, 0010 and, 0011 or, 1000 slt, 1001 nor, 0100 sll, 0101 srl.
- `a`, `b`  in  WIDTH  operands; shifts operate on `b`.
- `shamt`  in  5  shift amount.
- `in_tag`  in  TAGW  destination tag.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  downstream accepts the result.
- `result`  out  WIDTH  result.
- `zero`  out  1  result equals 0.
- `overflow`  out  1  signed overflow on add/sub.
- `illegal`  out  1  undefined `alu_ctrl` code.
- `out_tag`  out  TAGW  tag of the held result.

## Operation
- **States:** IDLE, SHIFT.
- **Output register:** one register holds result, flags and tag.
- **in_ready** = `rst_n` && !`flush` && state==IDLE && (!`out_valid` || `out_ready`). Combinational, with no dependency on `in_valid`.
- **Accept:** occurs on an edge where `in_valid` && `in_ready`.
- **Single-cycle path:** taken for non-shift codes, for shifts with `shamt`≤1, and for illegal codes. The output register loads on the accept edge and `out_valid` is set.
- **Serial shift path:** taken for sll/srl with `shamt`=n≥2.
  - The accept edge loads the shift register with `b` shifted by 1 and sets count=n−1. State goes to SHIFT.
  - Each SHIFT edge shifts by one more bit and decrements count.
  - On the edge where count==1, the output register loads the final value, `out_valid` is set, and state returns to IDLE.
- **add/sub:** modulo 2^WIDTH. `overflow` = operand signs match (for sub, `a` vs ~`b`) and the result sign differs. `overflow` is 0 for every other op.
- **slt:** signed compare; result is 1 or 0.
- **nor:** ~(`a`|`b`).
- **srl:** logical shift; zero fill.
- **zero:** set when `result`==0, for every op including illegal.
- **Illegal code:** `result`=0, `zero`=1, `illegal`=1, `overflow`=0. It still produces an output so the pipeline never hangs.
- **Output hold:** `out_valid` stays high with `result`, flags and `out_tag` stable until an edge with `out_ready`=1. That edge clears `out_valid` unless a new accept reloads it on the same edge.
- **flush:** at the next edge, `out_valid`←0, state←IDLE and any shift is discarded. No accept occurs in a flush cycle. Flush has priority over `out_ready` and over completion of a shift.
- **Reset:** while `rst_n` is low, `out_valid`, `result`, `zero`, `overflow`, `illegal` and `out_tag` are 0, state is IDLE and `in_ready`=0. After deassertion, `in_ready`=1.

## Timing
- Latency is counted in edges, with the accept edge as edge 1. `out_valid` rises after edge max(1, n) for shifts and after edge 1 for all other ops.
- **Throughput:** one non-shift op per cycle when `out_ready` is held high. A shift of n≥2 blocks `in_ready` for n−1 cycles after accept.
- A result is observable on the output for at least one cycle before it can be consumed. There is no combinational path from the inputs to `result`.
- **Reset mid-shift:** asserting `rst_n` low during SHIFT immediately clears state and outputs. No partial result is ever emitted.
- **Back-pressure:** with `out_ready` low and `out_valid` high, `in_ready` stays 0. A completed shift cannot be overwritten.

## Test plan
- **add overflow:** reset, then add with `a`=0x7FFFFFFF, `b`=1, tag 7. Response after 1 edge: `result`=0x80000000, `overflow`=1, `zero`=0, `out_tag`=7.
- **sub, slt, nor back-to-back**, with `out_ready`=1 and one op per cycle:
  - sub 5−5 → `result`=0, `zero`=1.
  - slt `a`=0xFFFFFFFF, `b`=1 → `result`=1.
  - nor 0,0 → `result`=0xFFFFFFFF.
  - Expect 3 consecutive valid results with no stall.
- **sll serial shift:** sll with `b`=0x1, `shamt`=4.
  - `in_ready` is 0 for 3 cycles.
  - `out_valid` rises after edge 4 with `result`=0x10.
  - srl `b`=0x80000000, `shamt`=31 → `result`=0x1 after edge 31.
- **Illegal code and shamt 0:** `alu_ctrl`=0111 → `result`=0, `illegal`=1, `zero`=1. sll with `shamt`=0 and `b`=0xABCD → `result`=0xABCD after edge 1.
- **Back-pressure:** hold `out_ready`=0 for 5 cycles after an or of 0xF0 and 0x0F.
  - `result`=0xFF stays stable and `in_ready`=0.
  - Raise `out_ready`; the next queued op is accepted on that same edge.
- **flush and reset mid-shift:** start sll with `shamt`=20 and assert `flush` at cycle 5. `out_valid` never rises, and `in_ready`=1 on the cycle after the flush. Repeat with `rst_n` pulsed low instead; all outputs go to 0 immediately.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with single-cycle ops and a serial one-bit-per-cycle shifter
// Registered result/flags/tag with valid/ready handshakes on both sides.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic [TAGW-1:0]  out_tag
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1001;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam int         MSB    = WIDTH - 1;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [4:0]       r_count;
    logic             r_shl;
    logic [TAGW-1:0]  r_shtag;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_illegal;
    logic [TAGW-1:0]  r_out_tag;

    logic             w_accept;
    logic             w_is_shift;
    logic             w_serial;
    logic             w_done;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_ill;
    logic [WIDTH-1:0] w_first_shift;
    logic [WIDTH-1:0] w_shift_next;

    assign in_ready   = rst_n && !flush && (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL);
    assign w_serial   = w_is_shift && (shamt >= 5'd2);
    assign w_done     = (r_state == S_SHIFT) && (r_count == 5'd1);

    assign w_sum  = a + b;
    assign w_diff = a - b;

    assign w_first_shift = (alu_ctrl == OP_SLL) ? {b[MSB-1:0], 1'b0} : {1'b0, b[MSB:1]};
    assign w_shift_next  = r_shl ? {r_shreg[MSB-1:0], 1'b0} : {1'b0, r_shreg[MSB:1]};

    // Shifts reaching this path have shamt of 0 or 1; longer shifts go serial.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR: w_res = ~(a | b);
            OP_SLL: w_res = shamt[0] ? {b[MSB-1:0], 1'b0} : b;
            OP_SRL: w_res = shamt[0] ? {1'b0, b[MSB:1]} : b;
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && w_serial) w_state_nxt = S_SHIFT;
                S_SHIFT: if (r_count == 5'd1) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg     <= '0;
            r_count     <= '0;
            r_shl       <= 1'b0;
            r_shtag     <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_tag   <= '0;
        end else begin
            if (w_accept && w_serial) begin
                r_shreg <= w_first_shift;
                r_count <= shamt - 5'd1;
                r_shl   <= (alu_ctrl == OP_SLL);
                r_shtag <= in_tag;
            end else if (r_state == S_SHIFT) begin
                r_shreg <= w_shift_next;
                r_count <= r_count - 5'd1;
            end

            // Flush wins over both a finishing shift and a consume.
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept && !w_serial) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_zero      <= (w_res == '0);
                r_overflow  <= w_ovf;
                r_illegal   <= w_ill;
                r_out_tag   <= in_tag;
            end else if (w_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_shift_next;
                r_zero      <= (w_shift_next == '0);
                r_overflow  <= 1'b0;
                r_illegal   <= 1'b0;
                r_out_tag   <= r_shtag;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign illegal   = r_illegal;
    assign out_tag   = r_out_tag;

endmodule
